// File: rtl/fifo_pong_reader.sv
// fifo_pong_reader
//
// Drain-side serializer for the ping-pong FIFO. It dequeues one WIDTH-bit
// message from the upstream reader interface, then emits it as BEATS
// beats of BEAT bits each, least-significant beat first, through an
// enq-style writer interface. When the final beat of a message transfers
// in the same cycle that upstream has another message ready, the next
// message is loaded immediately, so back-to-back messages stream with no
// idle cycle between them.
//
// Ports
//   CLK            sole clock, rising edge
//   RST            asynchronous, active-high reset
//   in_first       head message of the upstream FIFO
//   in_first_rdy   in_first is valid
//   in_deq_rdy     upstream accepts a dequeue
//   in_deq_ena     dequeue strobe (one message per high cycle)
//   out_enq_rdy    downstream accepts a beat
//   out_enq_ena    beat transfer strobe (only when out_enq_rdy)
//   out_enq_v      beat data
//   out_enq_last   marks the final beat of a message
//   msg_count      number of messages fully emitted, wraps at 16 bits
module fifo_pong_reader #(
    parameter int WIDTH = 704,
    parameter int BEAT  = 64,
    parameter int BEATS = 11
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] in_first,
    input  logic             in_first_rdy,
    input  logic             in_deq_rdy,
    output logic             in_deq_ena,
    input  logic             out_enq_rdy,
    output logic             out_enq_ena,
    output logic [BEAT-1:0]  out_enq_v,
    output logic             out_enq_last,
    output logic [15:0]      msg_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(BEATS - 1);

    state_t           state_reg, state_next;
    logic [3:0]       idx_reg, idx_next;
    logic [WIDTH-1:0] hold_reg, hold_next;
    logic [15:0]      msg_count_reg, msg_count_next;

    logic             at_last;
    logic             beat_xfer;
    logic             take;

    // Holding register viewed as an array of beats; beat 0 is the LSBs.
    logic [BEAT-1:0]  beat_word [BEATS];

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            assign beat_word[gi] = hold_reg[gi*BEAT +: BEAT];
        end
    endgenerate

    // Next-state and output logic.
    always_comb begin
        at_last        = (state_reg == SEND) && (idx_reg == LAST_IDX);
        beat_xfer      = (state_reg == SEND) && out_enq_rdy;
        // A new message is accepted when idle, or when the final beat of
        // the current one leaves this very cycle (zero-bubble reload).
        take           = in_first_rdy && in_deq_rdy &&
                         ((state_reg == IDLE) || (beat_xfer && at_last));

        state_next     = state_reg;
        idx_next       = idx_reg;
        hold_next      = hold_reg;
        msg_count_next = msg_count_reg;

        if (beat_xfer) begin
            if (at_last) begin
                msg_count_next = msg_count_reg + 16'd1;
                state_next     = IDLE;
                idx_next       = '0;
            end else begin
                idx_next       = idx_reg + 4'd1;
            end
        end

        // Reload overrides the return to IDLE on a final-beat transfer.
        if (take) begin
            hold_next  = in_first;
            idx_next   = '0;
            state_next = SEND;
        end
    end

    // The dequeue strobe is combinational; it is masked while reset is
    // held so that no upstream message is consumed during reset.
    assign in_deq_ena   = take && !RST;
    assign out_enq_ena  = beat_xfer;
    assign out_enq_last = at_last;
    assign msg_count    = msg_count_reg;

    // Driven from the holding register in every state so the bus stays
    // deterministic (all zero after reset) even while idle.
    always_comb begin
        out_enq_v = '0;
        if (idx_reg <= LAST_IDX) begin
            out_enq_v = beat_word[idx_reg];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            hold_reg      <= '0;
            msg_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            hold_reg      <= hold_next;
            msg_count_reg <= msg_count_next;
        end
    end

endmodule

// File: tb/tb_fifo_pong_reader.sv
module tb_fifo_pong_reader;

    localparam int WIDTH = 704;
    localparam int BEAT  = 64;
    localparam int BEATS = 11;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [WIDTH-1:0] first_v = '0;
    logic             first_rdy = 1'b0;
    logic             deq_rdy = 1'b0;
    logic             deq_ena;
    logic             enq_rdy = 1'b0;
    logic             enq_ena;
    logic [BEAT-1:0]  enq_v;
    logic             enq_last;
    logic [15:0]      msg_count;

    fifo_pong_reader #(.WIDTH(WIDTH), .BEAT(BEAT), .BEATS(BEATS)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_first     (first_v),
        .in_first_rdy (first_rdy),
        .in_deq_rdy   (deq_rdy),
        .in_deq_ena   (deq_ena),
        .out_enq_rdy  (enq_rdy),
        .out_enq_ena  (enq_ena),
        .out_enq_v    (enq_v),
        .out_enq_last (enq_last),
        .msg_count    (msg_count)
    );

    always #10 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: upstream FIFO contents, expected beat stream,
    // expected message count.
    logic [WIDTH-1:0] up_q [$];
    logic [BEAT-1:0]  exp_data [$];
    bit               exp_last [$];
    logic [15:0]      model_count = '0;

    bit  quiet = 1'b1;
    bit  pending_pop = 1'b0;
    int  pushed_now = 0;
    int  rdy_mode = 0;      // 0: always ready, 1: pattern 1,0,0,1, 2: random
    int  deq_pct = 100;
    int  pat = 0;
    int  cyc = 0;
    int  beat_total = 0;
    int  first_cyc = 0;
    int  last_cyc = 0;
    int  deq_cnt = 0;
    int  deq_beats [$];
    logic exp_take;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_msg();
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH/32; i++) m[i*32 +: 32] = $urandom();
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] counting_msg();
        logic [WIDTH-1:0] m;
        for (int k = 0; k < BEATS; k++) m[k*BEAT +: BEAT] = 64'h1000 + 64'(k);
        return m;
    endfunction

    task automatic clear_stats();
        beat_total = 0;
        first_cyc  = 0;
        last_cyc   = 0;
        deq_cnt    = 0;
        deq_beats.delete();
    endtask

    // Upstream FIFO / downstream ready driver; predicts when a dequeue
    // must happen and pushes the expected beats of each dequeued message.
    initial begin : driver
        logic [WIDTH-1:0] tmp;
        forever begin
            @(negedge CLK);
            if (pending_pop) begin
                tmp = up_q.pop_front();
                pending_pop = 1'b0;
            end
            if (up_q.size() > 0) begin
                first_v   = up_q[0];
                first_rdy = 1'b1;
            end else begin
                first_v   = rand_msg();
                first_rdy = 1'b0;
            end
            deq_rdy = ($urandom_range(99) < deq_pct);
            case (rdy_mode)
                0:       enq_rdy = 1'b1;
                1:       enq_rdy = ((pat % 4) == 0) || ((pat % 4) == 3);
                default: enq_rdy = ($urandom_range(99) < 70);
            endcase
            pat++;
            pushed_now = 0;
            #2;
            if (!quiet) begin
                // Free to accept when nothing is outstanding, or only the
                // last beat remains and it leaves this cycle.
                exp_take = first_rdy && deq_rdy &&
                           ((exp_data.size() == 0) || (exp_data.size() == 1 && enq_rdy));
                chk("deq_ena", deq_ena, exp_take);
                if (deq_ena && first_rdy) begin
                    deq_cnt++;
                    if (enq_ena) deq_beats.push_back(beat_total);
                    for (int k = 0; k < BEATS; k++) begin
                        exp_data.push_back(first_v[k*BEAT +: BEAT]);
                        exp_last.push_back(k == BEATS-1);
                    end
                    pushed_now  = BEATS;
                    pending_pop = 1'b1;
                end
            end
        end
    end

    // Monitor: pops and compares every presented beat.
    initial begin : monitor
        logic [BEAT-1:0] d;
        bit              l;
        forever begin
            @(negedge CLK);
            #3;
            cyc++;
            if (!quiet) begin
                chk("msg_count", msg_count, model_count);
                if (enq_ena) begin
                    chk("ena_needs_rdy", enq_rdy, 1);
                    if (exp_data.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL spurious_beat: got beat 0x%0h, expected no beat (t=%0t)", enq_v, $time);
                    end else begin
                        d = exp_data.pop_front();
                        l = exp_last.pop_front();
                        chk("beat_data", enq_v, d);
                        chk("beat_last", enq_last, l);
                        if (l) model_count = model_count + 16'd1;
                    end
                    if (beat_total == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beat_total++;
                end else if (enq_rdy && (exp_data.size() > pushed_now)) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL stalled_beat: got no beat, expected 0x%0h (t=%0t)", exp_data[0], $time);
                end
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (up_q.size() != 0 || exp_data.size() != 0 || pending_pop) begin
            @(negedge CLK);
            #4;
            n++;
            if (n > budget) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_timeout: got %0d beats pending, expected 0", name, exp_data.size());
                return;
            end
        end
        @(negedge CLK);
        #4;
    endtask

    task automatic apply_reset_and_check(input string name);
        // Called at negedge+4; assert between the monitor and the posedge.
        #1;
        quiet = 1'b1;
        RST = 1'b1;
        #1;
        chk({name, "_deq_ena"}, deq_ena, 0);
        chk({name, "_enq_ena"}, enq_ena, 0);
        chk({name, "_enq_last"}, enq_last, 0);
        chk({name, "_msg_count"}, msg_count, 0);
        chk({name, "_enq_v"}, enq_v, 0);
        exp_data.delete();
        exp_last.delete();
        model_count = '0;
        pending_pop = 1'b0;
        repeat (2) @(negedge CLK);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        quiet = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int bt;
        // Reset with upstream valid and ready.
        up_q.push_back(counting_msg());
        rdy_mode = 0;
        deq_pct  = 100;
        @(negedge CLK);
        #4;
        clear_stats();
        apply_reset_and_check("reset");

        // Single message 0x1000..0x100A; taken on the first edge after release.
        wait_drain("single", 40);
        chk("single_beats", beat_total, BEATS);
        chk("single_span", last_cyc - first_cyc, BEATS-1);
        chk("single_deq", deq_cnt, 1);
        chk("single_count", msg_count, 1);
        $display("single message: %0d beats, msg_count=%0d", beat_total, msg_count);

        // Back-to-back: three messages.
        clear_stats();
        repeat (3) up_q.push_back(rand_msg());
        wait_drain("b2b", 80);
        chk("b2b_beats", beat_total, 3*BEATS);
        chk("b2b_span", last_cyc - first_cyc, 3*BEATS-1);
        chk("b2b_deq_n", deq_beats.size(), 2);
        if (deq_beats.size() == 2) begin
            chk("b2b_deq_at_10", deq_beats[0], 10);
            chk("b2b_deq_at_21", deq_beats[1], 21);
        end
        chk("b2b_count", msg_count, 4);
        $display("back-to-back: %0d beats over %0d cycles", beat_total, last_cyc - first_cyc + 1);

        // Backpressure pattern 1,0,0,1.
        clear_stats();
        rdy_mode = 1;
        repeat (2) up_q.push_back(rand_msg());
        wait_drain("bp", 120);
        chk("bp_beats", beat_total, 2*BEATS);
        $display("backpressure: %0d beats", beat_total);

        // Upstream gap of 5 cycles between messages.
        clear_stats();
        rdy_mode = 0;
        up_q.push_back(rand_msg());
        wait_drain("gap1", 40);
        bt = beat_total;
        repeat (5) begin
            @(negedge CLK);
            #4;
            chk("gap_enq_ena", enq_ena, 0);
        end
        chk("gap_idle_beats", beat_total, bt);
        up_q.push_back(rand_msg());
        wait_drain("gap2", 40);
        chk("gap_beats", beat_total, bt + BEATS);
        $display("upstream gap: %0d beats", beat_total);

        // Randomized traffic on both sides.
        rdy_mode = 2;
        deq_pct  = 60;
        for (int m = 0; m < 30; m++) begin
            up_q.push_back(rand_msg());
            repeat ($urandom_range(0, 15)) begin
                @(negedge CLK);
                #4;
            end
        end
        wait_drain("random", 3000);
        $display("random: msg_count=%0d", msg_count);

        // Counter wrap: preload to 0xFFFE, two more messages reach 0x0000.
        rdy_mode = 0;
        deq_pct  = 100;
        #1;
        force dut.msg_count_reg = 16'hFFFE;
        #1;
        release dut.msg_count_reg;
        model_count = 16'hFFFE;
        @(negedge CLK);
        #4;
        repeat (2) up_q.push_back(rand_msg());
        wait_drain("wrap", 80);
        chk("wrap_count", msg_count, 16'h0000);
        $display("wrap: msg_count=0x%04h", msg_count);

        // Reset while beat 4 of a message is on the output.
        clear_stats();
        repeat (2) up_q.push_back(rand_msg());
        bt = 0;
        while (beat_total < 4 && bt < 40) begin
            @(negedge CLK);
            #4;
            bt++;
        end
        chk("midrst_reached_beat4", beat_total, 4);
        apply_reset_and_check("midrst");
        wait_drain("post_reset", 40);
        chk("post_reset_count", msg_count, 1);
        $display("mid-message reset: msg_count=%0d after one new message", msg_count);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
